tdm_demux_8: RTL
================

TDM_DEMUX_8 -- requirements
Module: tdm_demux_8

Interface
REQ-001 SHALL have parameter IDLE_LIMIT, default 15: maximum consecutive cycles without din_valid allowed mid-frame; legal range 1..255.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port din  input  1  serial data bit for the current slot.
REQ-005 SHALL have port din_valid  input  1  din is valid this cycle.
REQ-006 SHALL have port sof  input  1  start-of-frame; qualified by din_valid; marks the slot-0 bit.
REQ-007 SHALL have port s  output  3  index of the slot the next valid bit is written to.
REQ-008 SHALL have port d_out  output  8  last completed frame; d_out[i] = bit received in slot i.
REQ-009 SHALL have port frame_valid  output  1  one-cycle pulse when d_out updates.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse on an aborted frame.
REQ-011 SHALL have port busy  output  1  high while in COLLECT.

Function
REQ-012 SHALL implement FSM states IDLE and COLLECT; all outputs registered.
REQ-013 IDLE: din_valid=1 with sof=0 SHALL be ignored; s stays 0.
REQ-014 IDLE: din_valid=1 with sof=1 SHALL write din to shadow[0], set s=1, go to COLLECT.
REQ-015 COLLECT: din_valid=1 with sof=0 SHALL write din to shadow[s], then increment s.
REQ-016 COLLECT: at the edge capturing slot 7, SHALL load d_out <= {din, shadow[6:0]}, assert frame_valid for exactly that next cycle, set s=0, go to IDLE.
REQ-017 Latency SHALL be 1 cycle from the slot-7 valid bit to d_out/frame_valid visible.
REQ-018 COLLECT: din_valid=1 with sof=1 (any slot, including slot 7) SHALL pulse frame_err, leave d_out unchanged, write din to shadow[0], set s=1, stay in COLLECT.
REQ-019 Back-to-back frames (sof on the cycle after slot 7) SHALL be accepted via REQ-014 with no dead cycle.
REQ-020 COLLECT SHALL count consecutive cycles with din_valid=0; any valid bit clears the counter.
REQ-021 When the counter reaches IDLE_LIMIT, SHALL pulse frame_err, set s=0, go to IDLE, leave d_out unchanged.
REQ-022 din and sof SHALL be ignored when din_valid=0.
REQ-023 frame_valid and frame_err SHALL never be high in the same cycle.
REQ-024 d_out SHALL hold its value between completed frames; shadow contents SHALL never appear on d_out except via REQ-016.
REQ-025 busy SHALL equal (state == COLLECT).

Reset
REQ-026 rst_n=0 SHALL immediately, without a clock edge, force state IDLE, s=0, d_out=8'h00, frame_valid=0, frame_err=0, busy=0, idle counter=0, shadow=0.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame with no frame_err or frame_valid pulse.
REQ-028 After rst_n deasserts, the first frame SHALL be accepted only on din_valid & sof.

Verification
REQ-029 Slots 0..7 bits 0,1,0,1,0,1,1,1 on consecutive cycles, sof with slot 0 -> d_out=8'hEA, one frame_valid pulse, s sequence 0,1,...,7,0.
REQ-030 Frame 8'hEA, then immediately frame 8'h23 (bits 1,1,0,0,0,1,0,0), then 8'h00 back-to-back -> three frame_valid pulses 8 cycles apart; d_out EA, 23, 00 in order.
REQ-031 Frame 8'h23 with 3-cycle din_valid gaps after slots 2 and 5 (IDLE_LIMIT=15) -> d_out=8'h23, no frame_err.
REQ-032 4 bits sent, then din_valid low for 15 cycles -> frame_err pulse on the 15th, s=0, busy=0, d_out retains previous value.
REQ-033 sof reasserted at slot 5, then full frame 8'hEA -> one frame_err at slot 5, then d_out=8'hEA.
REQ-034 rst_n pulsed low at slot 4 between clock edges -> s=0, d_out=8'h00, busy=0 immediately; no pulses; din_valid without sof then ignored.

Source files
------------

// File: rtl/tdm_demux_8.sv
`default_nettype none
// ============================================================================
//  Module      : tdm_demux_8
//  Description : Eight-slot serial TDM frame demultiplexer. Serial bits that
//                arrive with din_valid are gathered slot by slot into a shadow
//                register. A finished frame is published on d_out together
//                with a one-cycle frame_valid pulse. Frames are aborted with a
//                one-cycle frame_err pulse when a new start-of-frame arrives
//                mid-frame, or when the input stays idle for too long.
//  Revision    : 1.0  initial release
// ============================================================================
module tdm_demux_8 #(
    parameter int IDLE_LIMIT = 15        // max consecutive idle cycles mid-frame (1..255)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       din,
    input  logic       din_valid,
    input  logic       sof,
    output logic [2:0] s,
    output logic [7:0] d_out,
    output logic       frame_valid,
    output logic       frame_err,
    output logic       busy
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [0:0] c_st_idle    = 1'b0;
    localparam logic [0:0] c_st_collect = 1'b1;

    localparam logic [2:0] c_last_slot  = 3'd7;

    // The abort fires on the edge that would make the idle count equal
    // IDLE_LIMIT, so the count is compared against IDLE_LIMIT-1.
    localparam logic [7:0] c_limit_m1   = 8'(IDLE_LIMIT - 1);

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [0:0] r_state;
    logic [6:0] r_shadow;      // slots 0..6; slot 7 goes straight to d_out
    logic [7:0] r_idle_cnt;    // consecutive idle cycles inside a frame

    // ------------------------------------------------------------------------
    // Next-state / next-value wires
    // ------------------------------------------------------------------------
    logic [0:0] w_state_nxt;
    logic [6:0] w_shadow_nxt;
    logic [7:0] w_idle_cnt_nxt;
    logic [2:0] w_s_nxt;
    logic [7:0] w_d_out_nxt;
    logic       w_frame_valid_nxt;
    logic       w_frame_err_nxt;
    logic       w_busy_nxt;

    // Qualified input events
    logic       w_bit_sof;     // valid bit that starts a frame
    logic       w_bit_data;    // valid bit that continues a frame
    logic       w_last_bit;    // valid continuation bit for slot 7
    logic       w_timeout;     // idle gap has reached the limit this edge

    assign w_bit_sof  = din_valid &  sof;
    assign w_bit_data = din_valid & ~sof;
    assign w_last_bit = w_bit_data & (s == c_last_slot);
    assign w_timeout  = (r_state == c_st_collect) & ~din_valid
                        & (r_idle_cnt == c_limit_m1);

    // State register: asynchronous reset forces IDLE at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: enter on sof, leave on frame completion or idle timeout
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_bit_sof) begin
                    w_state_nxt = c_st_collect;
                end
            end
            c_st_collect: begin
                // A mid-frame sof restarts the frame but stays in COLLECT.
                if (w_last_bit || w_timeout) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // Output and datapath next values for every input event in each state
    always_comb begin
        w_shadow_nxt      = r_shadow;
        w_idle_cnt_nxt    = r_idle_cnt;
        w_s_nxt           = s;
        w_d_out_nxt       = d_out;
        w_frame_valid_nxt = 1'b0;
        w_frame_err_nxt   = 1'b0;

        case (r_state)
            c_st_idle: begin
                // Outside a frame only sof matters; the idle count stays cleared.
                w_idle_cnt_nxt = 8'd0;
                if (w_bit_sof) begin
                    w_shadow_nxt[0] = din;
                    w_s_nxt         = 3'd1;
                end
            end

            c_st_collect: begin
                if (din_valid) begin
                    // Any valid bit ends an idle gap.
                    w_idle_cnt_nxt = 8'd0;
                    if (sof) begin
                        // Restart: drop the partial frame, keep d_out, report it.
                        w_frame_err_nxt = 1'b1;
                        w_shadow_nxt[0] = din;
                        w_s_nxt         = 3'd1;
                    end else if (s == c_last_slot) begin
                        // Slot 7 completes the frame; publish it directly.
                        w_d_out_nxt       = {din, r_shadow};
                        w_frame_valid_nxt = 1'b1;
                        w_s_nxt           = 3'd0;
                    end else begin
                        w_shadow_nxt[s] = din;
                        w_s_nxt         = s + 3'd1;
                    end
                end else if (w_timeout) begin
                    // Input went silent too long: abandon the frame.
                    w_frame_err_nxt = 1'b1;
                    w_s_nxt         = 3'd0;
                    w_idle_cnt_nxt  = 8'd0;
                end else begin
                    w_idle_cnt_nxt = r_idle_cnt + 8'd1;
                end
            end

            default: begin
                w_s_nxt        = 3'd0;
                w_idle_cnt_nxt = 8'd0;
            end
        endcase

        w_busy_nxt = (w_state_nxt == c_st_collect);
    end

    // Registered outputs and datapath; reset clears everything, including shadow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow    <= 7'd0;
            r_idle_cnt  <= 8'd0;
            s           <= 3'd0;
            d_out       <= 8'h00;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            r_shadow    <= w_shadow_nxt;
            r_idle_cnt  <= w_idle_cnt_nxt;
            s           <= w_s_nxt;
            d_out       <= w_d_out_nxt;
            frame_valid <= w_frame_valid_nxt;
            frame_err   <= w_frame_err_nxt;
            busy        <= w_busy_nxt;
        end
    end

endmodule
`default_nettype wire
